// File: rtl/serio_ocp_pkg.sv
// Shared encodings for the serial-command to OCP bridge: FSM states, OCP MCmd/SResp codes,
// and the ASCII opcode and reply bytes exchanged over the UART.
package serio_ocp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_CMD     = 3'd3,
    ST_WAIT    = 3'd4,
    ST_TX_STAT = 3'd5,
    ST_TX_DATA = 3'd6
  } state_t;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] REPLY_OK  = 8'h4B;
  localparam logic [7:0] REPLY_ERR = 8'h45;

  // Writes only fail on FAIL/ERR; reads must see DVA to succeed.
  function automatic logic [7:0] reply_status(input logic is_write, input logic [1:0] sresp);
    if (is_write)
      return (sresp == SRESP_FAIL || sresp == SRESP_ERR) ? REPLY_ERR : REPLY_OK;
    else
      return (sresp == SRESP_DVA) ? REPLY_OK : REPLY_ERR;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for partially received command frames.
module uart_frame_timer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic reload,
  output logic expired
);

  logic [15:0] cnt_reg;

  // Fires on the TIMEOUT_CYCLES-th consecutive running cycle without a received byte.
  assign expired = run && !reload && (cnt_reg == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= 16'd0;
    else if (!run || reload || expired)
      cnt_reg <= 16'd0;
    else
      cnt_reg <= cnt_reg + 16'd1;
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Decodes 'W' addr data / 'R' addr UART frames into single OCP transactions and replies
// with a status byte (plus data for reads). Optional frame timeout: UART_FRAME_TIMEOUT_EN.
module uart_cmd_master
  import serio_ocp_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] MCmd,
  output logic [7:0] MAddr,
  output logic [7:0] MData,
  input  logic       SCmdAccept,
  input  logic [7:0] SData,
  input  logic [1:0] SResp,
  output logic       overrun,
  output logic [2:0] state
);

  state_t     state_reg, state_next;
  logic       op_write_reg;
  logic [7:0] maddr_reg, mdata_reg, sdata_reg, status_reg;
  logic       overrun_reg;
  logic       wait_done;
  logic       frame_timeout;
  logic       is_opcode;
  logic       busy;

`ifdef UART_FRAME_TIMEOUT_EN
  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_reg == ST_ADDR || state_reg == ST_DATA),
    .reload (rx_valid),
    .expired(frame_timeout)
  );
`else
  // No timer in this build; the parameter is only referenced to keep the interface uniform.
  assign frame_timeout = (TIMEOUT_CYCLES == 16'd0) & 1'b0;
`endif

  assign is_opcode = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign wait_done = op_write_reg ? SCmdAccept : (SResp != SRESP_NULL);
  assign busy      = (state_reg == ST_CMD) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_TX_STAT) || (state_reg == ST_TX_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (rx_valid && is_opcode) state_next = ST_ADDR;
      ST_ADDR: begin
        if (rx_valid)           state_next = op_write_reg ? ST_DATA : ST_CMD;
        else if (frame_timeout) state_next = ST_IDLE;
      end
      ST_DATA: begin
        if (rx_valid)           state_next = ST_CMD;
        else if (frame_timeout) state_next = ST_IDLE;
      end
      ST_CMD:     if (SCmdAccept) state_next = ST_WAIT;
      ST_WAIT:    if (wait_done)  state_next = ST_TX_STAT;
      ST_TX_STAT: if (tx_ready)   state_next = op_write_reg ? ST_IDLE : ST_TX_DATA;
      ST_TX_DATA: if (tx_ready)   state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    MCmd     = MCMD_IDLE;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_reg)
      ST_CMD:     MCmd = op_write_reg ? MCMD_WR : MCMD_RD;
      ST_TX_STAT: begin
        tx_valid = 1'b1;
        tx_data  = status_reg;
      end
      ST_TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = (status_reg == REPLY_ERR) ? 8'h00 : sdata_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write_reg <= 1'b0;
      maddr_reg    <= 8'h00;
      mdata_reg    <= 8'h00;
      sdata_reg    <= 8'h00;
      status_reg   <= 8'h00;
      overrun_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && rx_valid && is_opcode)
        op_write_reg <= (rx_data == OP_WRITE);
      if (state_reg == ST_ADDR && rx_valid)
        maddr_reg <= rx_data;
      if (state_reg == ST_DATA && rx_valid)
        mdata_reg <= rx_data;
      if (state_reg == ST_WAIT && wait_done) begin
        status_reg <= reply_status(op_write_reg, SResp);
        if (!op_write_reg)
          sdata_reg <= SData;
      end
      if (busy && rx_valid)
        overrun_reg <= 1'b1;
    end
  end

  assign MAddr   = maddr_reg;
  assign MData   = mdata_reg;
  assign overrun = overrun_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: directed frames plus randomized transactions
// against a reply model; timeout scenario runs when UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_cmd_master;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] MCmd;
  logic [7:0] MAddr;
  logic [7:0] MData;
  logic       SCmdAccept;
  logic [7:0] SData;
  logic [1:0] SResp;
  logic       overrun;
  logic [2:0] state;

  int checks = 0;
  int fails  = 0;

  uart_cmd_master #(
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .MCmd      (MCmd),
    .MAddr     (MAddr),
    .MData     (MData),
    .SCmdAccept(SCmdAccept),
    .SData     (SData),
    .SResp     (SResp),
    .overrun   (overrun),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  // One complete frame with a cycle-level link responder; expected reply bytes come from
  // the protocol rules directly (status letter, then data or 00 for reads).
  task automatic run_frame(input string name, input bit is_wr, input logic [7:0] addr,
                           input logic [7:0] data, input int acc_dly, input int rsp_dly,
                           input logic [1:0] rsp, input logic [7:0] sdat, input bit inject);
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    logic [2:0] exp_cmd;
    int bad;
    int n;
    string txs;
    exp_cmd = is_wr ? 3'b001 : 3'b010;
    if (is_wr) begin
      exp_tx.push_back((rsp == 2'b10 || rsp == 2'b11) ? 8'h45 : 8'h4B);
    end else begin
      exp_tx.push_back((rsp == 2'b01) ? 8'h4B : 8'h45);
      exp_tx.push_back((rsp == 2'b01) ? sdat : 8'h00);
    end

    send_byte(is_wr ? 8'h57 : 8'h52);
    send_byte(addr);
    if (is_wr) send_byte(data);

    checks++;
    if (MCmd !== exp_cmd || MAddr !== addr || (is_wr && MData !== data)) begin
      fails++;
      $display("FAIL %s cmd_latency: MCmd=%b MAddr=%h MData=%h, expected %b %h %h",
               name, MCmd, MAddr, MData, exp_cmd, addr, data);
    end

    bad = 0;
    for (int i = 0; i < acc_dly; i++) begin
      tick();
      if (MCmd !== exp_cmd || MAddr !== addr || (is_wr && MData !== data)) bad++;
    end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s cmd_hold: %0d cycles with request changed, expected 0", name, bad);
    end
    checks++;
    if (MCmd !== 3'b000) begin
      fails++;
      $display("FAIL %s cmd_release: MCmd=%b after accept, expected 000", name, MCmd);
    end

    bad = 0;
    for (int i = 0; i < rsp_dly; i++) begin
      SData = $urandom_range(0, 255);
      if (inject && i == 0) begin
        rx_data  = 8'h57;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (MCmd !== 3'b000 || tx_valid !== 1'b0) bad++;
    end
    if (is_wr) begin
      SCmdAccept = 1'b1;
      SResp      = rsp;
    end else begin
      SResp = rsp;
      SData = sdat;
    end
    tick();
    SCmdAccept = 1'b0;
    SResp      = 2'b00;
    SData      = $urandom_range(0, 255);
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s wait_quiet: %0d cycles with MCmd/tx_valid active, expected 0", name, bad);
    end
    checks++;
    if (tx_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s tx_latency: tx_valid=%b after completion, expected 1", name, tx_valid);
    end

    n = 0;
    while (got_tx.size() < exp_tx.size() && n < 200) begin
      tx_ready = $urandom_range(0, 1);
      if (tx_ready && tx_valid) got_tx.push_back(tx_data);
      tick();
      n++;
    end
    tx_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (tx_valid !== 1'b0) bad++;
      tick();
    end
    tx_ready = 1'b0;

    checks++;
    if (got_tx.size() != exp_tx.size() || bad != 0) begin
      fails++;
      $display("FAIL %s tx_count: got %0d bytes + %0d extra cycles valid, expected %0d bytes",
               name, got_tx.size(), bad, exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      checks++;
      if (got_tx[i] !== exp_tx[i]) begin
        fails++;
        $display("FAIL %s tx_byte%0d: got %h, expected %h", name, i, got_tx[i], exp_tx[i]);
      end
    end
    checks++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL %s end_state: state=%0d, expected 0", name, state);
    end

    txs = "";
    foreach (got_tx[i]) txs = {txs, $sformatf(" %h", got_tx[i])};
    $display("txn %s op=%s addr=%h data=%h sresp=%b sdata=%h tx:%s", name,
             is_wr ? "W" : "R", addr, data, rsp, sdat, txs);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 3'd0 || MCmd !== 3'b000 || MAddr !== 8'h00 || MData !== 8'h00) begin
      fails++;
      $display("FAIL reset_ocp: state=%0d MCmd=%b MAddr=%h MData=%h, expected 0 000 00 00",
               state, MCmd, MAddr, MData);
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_tx: tx_valid=%b tx_data=%h overrun=%b, expected 0 00 0",
               tx_valid, tx_data, overrun);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset state=%0d", state);
  endtask

  task automatic test_ignore_garbage();
    int bad;
    logic [7:0] b;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      do b = $urandom_range(0, 255); while (b == 8'h57 || b == 8'h52);
      send_byte(b);
      if (state !== 3'd0 || tx_valid !== 1'b0 || MCmd !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL ignore_garbage: %0d bad cycles overrun=%b, expected 0 and 0", bad, overrun);
    end
    $display("txn garbage 10 bytes state=%0d", state);
  endtask

  task automatic test_directed();
    run_frame("write_ok", 1'b1, 8'h12, 8'hA5, 2, 1, 2'b00, 8'h00, 1'b0);
    run_frame("read_ok",  1'b0, 8'h85, 8'h00, 1, 2, 2'b01, 8'h3C, 1'b0);
    run_frame("read_err", 1'b0, 8'h20, 8'h00, 0, 0, 2'b11, 8'h99, 1'b0);
    run_frame("write_fail", 1'b1, 8'h7E, 8'h01, 0, 0, 2'b10, 8'h00, 1'b0);
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre: overrun=%b, expected 0", overrun);
    end
    run_frame("overrun_read", 1'b0, 8'h10, 8'h00, 1, 3, 2'b01, 8'hC7, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_post: overrun=%b, expected 1", overrun);
    end
    run_frame("overrun_sticky", 1'b1, 8'h33, 8'h44, 0, 0, 2'b00, 8'h00, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: overrun=%b, expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bad = 0;
    send_byte(8'h57);
    send_byte(8'h40);
    if (MCmd !== 3'b000) bad++;
    rst_n = 1'b0;
    tick();
    if (state !== 3'd0 || MCmd !== 3'b000 || MAddr !== 8'h00 || overrun !== 1'b0) bad++;
    rst_n = 1'b1;
    tick();
    if (MCmd !== 3'b000 || state !== 3'd0) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_mid_frame: %0d bad observations, expected 0", bad);
    end
    $display("txn reset_mid_frame state=%0d overrun=%b", state, overrun);
    run_frame("read_after_reset", 1'b0, 8'h40, 8'h00, 1, 1, 2'b01, 8'h5A, 1'b0);
  endtask

  task automatic test_random();
    bit is_wr;
    logic [1:0] rsp;
    for (int k = 0; k < 20; k++) begin
      is_wr = $urandom_range(0, 1);
      rsp   = is_wr ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
      run_frame($sformatf("rand%0d", k), is_wr, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $urandom_range(0, 4), $urandom_range(0, 4),
                rsp, 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic test_frame_timeout();
    int bad;
    bad = 0;
    send_byte(8'h57);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (99) begin
      tick();
      if (MCmd !== 3'b000 || tx_valid !== 1'b0) bad++;
    end
    checks++;
    if (state !== 3'd1) begin
      fails++;
      $display("FAIL timeout_early: state=%0d after 99 cycles, expected 1", state);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL timeout_expire: state=%0d after 100 cycles, expected 0", state);
    end
    repeat (20) begin
      tick();
      if (MCmd !== 3'b000 || tx_valid !== 1'b0) bad++;
    end
`else
    repeat (150) begin
      tick();
      if (MCmd !== 3'b000 || tx_valid !== 1'b0) bad++;
    end
    checks++;
    if (state !== 3'd1) begin
      fails++;
      $display("FAIL no_timeout: state=%0d after 150 cycles, expected 1", state);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL timeout_quiet: %0d cycles with MCmd/tx active, expected 0", bad);
    end
    $display("txn frame_timeout state=%0d", state);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    SCmdAccept = 1'b0;
    SData      = 8'h00;
    SResp      = 2'b00;
    test_reset();
    test_ignore_garbage();
    test_directed();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    test_frame_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
